// File: rtl/pipe_slice_pkg.sv
// rtl/pipe_slice_pkg.sv - shared types and constants for the pipe_reg_slice skid pipeline
package pipe_slice_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } stage_state_e;

   localparam int PIPE_SLICE_MAX_STAGES = 8;

   // Counter must represent 0..2*stages inclusive.
   function automatic int occ_width(input int stages);
      return $clog2(2 * stages + 1);
   endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - one two-entry skid stage; ready, valid and data all come straight from registers
module pipe_skid_stage
   import pipe_slice_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_up_valid,
   input  logic [WIDTH-1:0] i_up_data,
   output logic             o_up_ready,
   output logic             o_dn_valid,
   output logic [WIDTH-1:0] o_dn_data,
   input  logic             i_dn_ready
);

   stage_state_e     r_state;
   stage_state_e     w_state_nxt;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] r_skid;
   logic [WIDTH-1:0] w_main_nxt;
   logic [WIDTH-1:0] w_skid_nxt;
   logic             w_in;
   logic             w_out;

   assign o_up_ready = (r_state != FULL);
   assign o_dn_valid = (r_state != EMPTY);
   assign o_dn_data  = r_main;

   assign w_in  = i_up_valid && o_up_ready;
   assign w_out = o_dn_valid && i_dn_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= EMPTY;
         r_main  <= '0;
         r_skid  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_main  <= w_main_nxt;
         r_skid  <= w_skid_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      case (r_state)
         EMPTY: begin
            if (w_in) begin
               w_state_nxt = BUSY;
               w_main_nxt  = i_up_data;
            end
         end
         BUSY: begin
            if (w_in && w_out) begin
               w_main_nxt = i_up_data;
            end else if (w_in) begin
               // Downstream stalled: park the new beat so ready can drop a cycle late.
               w_state_nxt = FULL;
               w_skid_nxt  = i_up_data;
            end else if (w_out) begin
               w_state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (w_out) begin
               w_state_nxt = BUSY;
               w_main_nxt  = r_skid;
            end
         end
         default: begin
            w_state_nxt = EMPTY;
         end
      endcase
   end

endmodule

// File: rtl/pipe_reg_slice.sv
// rtl/pipe_reg_slice.sv - STAGES cascaded skid stages, 2*STAGES beats of capacity, full throughput
// Define PIPE_SLICE_OCC_EN to add the o_occupancy port and its counter.
module pipe_reg_slice
   import pipe_slice_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            i_valid,
   input  logic [WIDTH-1:0]                i_data,
   output logic                            o_ready,
   output logic                            o_valid,
   output logic [WIDTH-1:0]                o_data,
`ifdef PIPE_SLICE_OCC_EN
   output logic [occ_width(STAGES)-1:0]    o_occupancy,
`endif
   input  logic                            i_ready
);

   if (STAGES < 1 || STAGES > PIPE_SLICE_MAX_STAGES) begin : g_bad_stages
      $error("pipe_reg_slice: STAGES must be within 1..%0d", PIPE_SLICE_MAX_STAGES);
   end

   // Link k is the up-side of stage k; link STAGES is the output port.
   logic             w_valid [0:STAGES];
   logic [WIDTH-1:0] w_data  [0:STAGES];
   logic             w_ready [0:STAGES];

   assign w_valid[0]      = i_valid;
   assign w_data[0]       = i_data;
   assign o_ready         = w_ready[0];
   assign o_valid         = w_valid[STAGES];
   assign o_data          = w_data[STAGES];
   assign w_ready[STAGES] = i_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      pipe_skid_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk        (clk),
         .reset      (reset),
         .i_up_valid (w_valid[k]),
         .i_up_data  (w_data[k]),
         .o_up_ready (w_ready[k]),
         .o_dn_valid (w_valid[k+1]),
         .o_dn_data  (w_data[k+1]),
         .i_dn_ready (w_ready[k+1])
      );
   end

`ifdef PIPE_SLICE_OCC_EN
   localparam int OCC_W = occ_width(STAGES);

   logic [OCC_W-1:0] r_occ;
   logic             w_up_xfer;
   logic             w_dn_xfer;

   assign w_up_xfer   = i_valid && o_ready;
   assign w_dn_xfer   = o_valid && i_ready;
   assign o_occupancy = r_occ;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_occ <= '0;
      end else if (w_up_xfer && !w_dn_xfer) begin
         r_occ <= r_occ + OCC_W'(1);
      end else if (!w_up_xfer && w_dn_xfer) begin
         r_occ <= r_occ - OCC_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_reg_slice.sv
// tb/tb_pipe_reg_slice.sv - vector table, streaming sequence and queue-model random stress for pipe_reg_slice
module tb_pipe_reg_slice;

   localparam int DS = 2;

   logic       clk;
   logic       rst_n;
   logic       i_valid;
   logic [7:0] i_data;
   logic       o_ready;
   logic       o_valid;
   logic [7:0] o_data;
   logic       i_ready;
`ifdef PIPE_SLICE_OCC_EN
   logic [$clog2(2*DS+1)-1:0] o_occupancy;
`endif

   int n_tests;
   int n_fails;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pipe_reg_slice #(
      .WIDTH  (8),
      .STAGES (DS)
   ) u_dut (
      .clk         (clk),
      .reset       (rst_n),
      .i_valid     (i_valid),
      .i_data      (i_data),
      .o_ready     (o_ready),
      .o_valid     (o_valid),
      .o_data      (o_data),
`ifdef PIPE_SLICE_OCC_EN
      .o_occupancy (o_occupancy),
`endif
      .i_ready     (i_ready)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       rst;
      logic       v;
      logic [7:0] d;
      logic       ir;
      logic       ce;
      logic       ev;
      logic [7:0] ed;
      logic       cd;
      logic       er;
      int         eocc;
   } vec_t;

   function automatic vec_t mk(input logic rst, input logic v, input logic [7:0] d, input logic ir,
                               input logic ce, input logic ev, input logic [7:0] ed, input logic cd,
                               input logic er, input int eocc);
      vec_t r;
      r.rst = rst; r.v = v; r.d = d; r.ir = ir;
      r.ce = ce; r.ev = ev; r.ed = ed; r.cd = cd; r.er = er; r.eocc = eocc;
      return r;
   endfunction

   // Random stress: one slice per shape, checked against an in-order queue of held beats.
   for (genvar g = 0; g < 3; g++) begin : g_stress
      localparam int ST = (g == 0) ? 1 : (g == 1) ? 3 : 8;
      localparam int W  = (g == 0) ? 1 : (g == 1) ? 8 : 32;

      logic         s_reset;
      logic         s_ivalid;
      logic [W-1:0] s_idata;
      logic         s_oready;
      logic         s_ovalid;
      logic [W-1:0] s_odata;
      logic         s_iready;
      bit           done;
`ifdef PIPE_SLICE_OCC_EN
      logic [$clog2(2*ST+1)-1:0] s_occ;
`endif

      pipe_reg_slice #(
         .WIDTH  (W),
         .STAGES (ST)
      ) u_s (
         .clk         (clk),
         .reset       (s_reset),
         .i_valid     (s_ivalid),
         .i_data      (s_idata),
         .o_ready     (s_oready),
         .o_valid     (s_ovalid),
         .o_data      (s_odata),
`ifdef PIPE_SLICE_OCC_EN
         .o_occupancy (s_occ),
`endif
         .i_ready     (s_iready)
      );

      initial begin : stress
         logic [W-1:0] q[$];
         int rcvd;
         int cyc;
         logic up;
         logic dn;
         done     = 1'b0;
         s_reset  = 1'b0;
         s_ivalid = 1'b0;
         s_idata  = '0;
         s_iready = 1'b0;
         repeat (2) @(posedge clk);
         #1;
         s_reset = 1'b1;
         rcvd = 0;
         cyc  = 0;
         while (rcvd < 1000 && cyc < 20000) begin
            s_ivalid = 1'($urandom_range(0, 1));
            s_idata  = W'($urandom);
            s_iready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk($sformatf("stress%0d_depth_bound", g), 64'(q.size() <= 2 * ST), 64'(1));
            if (q.size() == 2 * ST)
               chk($sformatf("stress%0d_ready_when_full", g), 64'(s_oready), 64'(0));
            if (s_ovalid) begin
               if (q.size() == 0)
                  chk($sformatf("stress%0d_spurious_valid", g), 64'(s_ovalid), 64'(0));
               else
                  chk($sformatf("stress%0d_data", g), 64'(s_odata), 64'(q[0]));
            end
`ifdef PIPE_SLICE_OCC_EN
            chk($sformatf("stress%0d_occupancy", g), 64'(s_occ), 64'(q.size()));
`endif
            up = s_ivalid && s_oready;
            dn = s_ovalid && s_iready;
            if (dn && q.size() > 0) begin
               void'(q.pop_front());
               rcvd++;
            end
            if (up) q.push_back(s_idata);
            @(posedge clk);
            #1;
            cyc++;
         end
         chk($sformatf("stress%0d_beats_delivered", g), 64'(rcvd >= 1000), 64'(1));
         done = 1'b1;
      end
   end

   initial begin : main
      vec_t vecs [28];
      int   wait_cyc;

      n_tests = 0;
      n_fails = 0;

      vecs[0]  = mk(0, 0, 8'h00, 0,  0, 0, 8'h00, 0, 1, 0);
      vecs[1]  = mk(0, 0, 8'h00, 0,  1, 0, 8'h00, 1, 1, 0);
      vecs[2]  = mk(1, 0, 8'h00, 1,  1, 0, 8'h00, 1, 1, 0);
      vecs[3]  = mk(1, 1, 8'h6F, 1,  1, 0, 8'h00, 1, 1, 0);
      vecs[4]  = mk(1, 1, 8'h70, 1,  1, 0, 8'h00, 1, 1, 1);
      vecs[5]  = mk(1, 0, 8'h00, 1,  1, 1, 8'h6F, 1, 1, 2);
      vecs[6]  = mk(1, 0, 8'h00, 1,  1, 1, 8'h70, 1, 1, 1);
      vecs[7]  = mk(1, 0, 8'h00, 0,  1, 0, 8'h00, 0, 1, 0);
      vecs[8]  = mk(1, 1, 8'h74, 0,  1, 0, 8'h00, 0, 1, 0);
      vecs[9]  = mk(1, 1, 8'h75, 0,  1, 0, 8'h00, 0, 1, 1);
      vecs[10] = mk(1, 1, 8'h76, 0,  1, 1, 8'h74, 1, 1, 2);
      vecs[11] = mk(1, 1, 8'h77, 0,  1, 1, 8'h74, 1, 1, 3);
      vecs[12] = mk(1, 1, 8'h78, 0,  1, 1, 8'h74, 1, 0, 4);
      vecs[13] = mk(1, 1, 8'h78, 0,  1, 1, 8'h74, 1, 0, 4);
      vecs[14] = mk(1, 0, 8'h00, 1,  1, 1, 8'h74, 1, 0, 4);
      vecs[15] = mk(1, 0, 8'h00, 1,  1, 1, 8'h75, 1, 0, 3);
      vecs[16] = mk(1, 0, 8'h00, 1,  1, 1, 8'h76, 1, 1, 2);
      vecs[17] = mk(1, 0, 8'h00, 1,  1, 1, 8'h77, 1, 1, 1);
      vecs[18] = mk(1, 0, 8'h00, 0,  1, 0, 8'h00, 0, 1, 0);
      vecs[19] = mk(1, 1, 8'hA1, 0,  1, 0, 8'h00, 0, 1, 0);
      vecs[20] = mk(1, 1, 8'hA2, 0,  1, 0, 8'h00, 0, 1, 1);
      vecs[21] = mk(1, 1, 8'hA3, 0,  1, 1, 8'hA1, 1, 1, 2);
      vecs[22] = mk(0, 0, 8'h00, 1,  1, 1, 8'hA1, 1, 1, 3);
      vecs[23] = mk(1, 0, 8'h00, 1,  1, 0, 8'h00, 1, 1, 0);
      vecs[24] = mk(1, 1, 8'hB0, 1,  1, 0, 8'h00, 1, 1, 0);
      vecs[25] = mk(1, 0, 8'h00, 1,  1, 0, 8'h00, 0, 1, 1);
      vecs[26] = mk(1, 0, 8'h00, 1,  1, 1, 8'hB0, 1, 1, 1);
      vecs[27] = mk(1, 0, 8'h00, 0,  1, 0, 8'h00, 0, 1, 0);

      for (int i = 0; i < 28; i++) begin
         rst_n   = vecs[i].rst;
         i_valid = vecs[i].v;
         i_data  = vecs[i].d;
         i_ready = vecs[i].ir;
         @(negedge clk);
         if (vecs[i].ce) begin
            chk($sformatf("vec%0d_o_valid", i), 64'(o_valid), 64'(vecs[i].ev));
            chk($sformatf("vec%0d_o_ready", i), 64'(o_ready), 64'(vecs[i].er));
            if (vecs[i].cd)
               chk($sformatf("vec%0d_o_data", i), 64'(o_data), 64'(vecs[i].ed));
`ifdef PIPE_SLICE_OCC_EN
            chk($sformatf("vec%0d_occupancy", i), 64'(o_occupancy), 64'(vecs[i].eocc));
`endif
         end
         @(posedge clk);
         #1;
      end

      // Back-to-back stream: no bubbles, fixed DS-cycle latency, ready never drops.
      for (int c = 0; c < 24; c++) begin
         rst_n   = 1'b1;
         i_valid = (c < 20);
         i_data  = 8'(c + 16);
         i_ready = 1'b1;
         @(negedge clk);
         chk($sformatf("stream%0d_o_ready", c), 64'(o_ready), 64'(1));
         if (c >= DS && c < 20 + DS) begin
            chk($sformatf("stream%0d_o_valid", c), 64'(o_valid), 64'(1));
            chk($sformatf("stream%0d_o_data", c), 64'(o_data), 64'(c - DS + 16));
         end else begin
            chk($sformatf("stream%0d_o_valid", c), 64'(o_valid), 64'(0));
         end
         @(posedge clk);
         #1;
      end
      i_valid = 1'b0;

      wait_cyc = 0;
      while (!(g_stress[0].done && g_stress[1].done && g_stress[2].done) && wait_cyc < 70000) begin
         @(posedge clk);
         wait_cyc++;
      end
      chk("stress_all_finished",
          64'(g_stress[0].done && g_stress[1].done && g_stress[2].done), 64'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
      $finish;
   end

endmodule
